// File: rtl/traffic_pkg.sv
// +------------------------------------------------------------------+
// | traffic_pkg : state codes, lamp encodings, direction encoding    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        ST_HW_GREEN    = 3'd0,
        ST_HW_YELLOW   = 3'd1,
        ST_ALL_RED_1   = 3'd2,
        ST_FARM_GREEN  = 3'd3,
        ST_FARM_YELLOW = 3'd4,
        ST_ALL_RED_2   = 3'd5,
        ST_PED_WALK    = 3'd6
    } state_t;

    typedef enum logic {
        DIR_HW   = 1'b0,
        DIR_FARM = 1'b1
    } dir_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic logic [2:0] hw_lamp(input state_t s);
        case (s)
            ST_HW_GREEN:  return LAMP_GREEN;
            ST_HW_YELLOW: return LAMP_YELLOW;
            default:      return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] farm_lamp(input state_t s);
        case (s)
            ST_FARM_GREEN:  return LAMP_GREEN;
            ST_FARM_YELLOW: return LAMP_YELLOW;
            default:        return LAMP_RED;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// +------------------------------------------------------------------+
// | tick_gen : one-cycle tick every TICK_DIV clocks                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] c_tick_last = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == c_tick_last) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = (r_cnt == c_tick_last);

endmodule

`default_nettype wire

// File: rtl/intersection_scheduler.sv
// +------------------------------------------------------------------+
// | intersection_scheduler : tick-timed highway/farm/pedestrian FSM  |
// | Option macro PED_EN adds ped_req/walk and the walk phase.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV       = 1000,
    parameter int HW_MIN_GREEN   = 25,
    parameter int FARM_MIN_GREEN = 5,
    parameter int FARM_MAX_GREEN = 15,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int WALK_T         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
`ifdef PED_EN
    input  logic       ped_req,
`endif
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
`ifdef PED_EN
    output logic       walk,
`endif
    output logic [2:0] phase
);

    logic       w_tick;
    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_phase_time;
    dir_t       r_next_dir;
    logic       w_ped_pending;
    logic [2:0] r_lamp_hw;
    logic [2:0] r_lamp_farm;
    logic       w_enter_walk;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            case (r_state)
                ST_HW_GREEN:
                    if ((r_phase_time >= 8'(HW_MIN_GREEN - 1)) && (sensor || w_ped_pending))
                        w_next = ST_HW_YELLOW;
                ST_HW_YELLOW:
                    if (r_phase_time == 8'(YELLOW_T - 1)) w_next = ST_ALL_RED_1;
                ST_ALL_RED_1:
                    if (r_phase_time == 8'(ALL_RED_T - 1)) begin
                        if (w_ped_pending) w_next = ST_PED_WALK;
                        else if (sensor)   w_next = ST_FARM_GREEN;
                        else               w_next = ST_HW_GREEN;
                    end
                ST_FARM_GREEN:
                    if (((r_phase_time >= 8'(FARM_MIN_GREEN - 1)) && !sensor) ||
                        (r_phase_time == 8'(FARM_MAX_GREEN - 1)))
                        w_next = ST_FARM_YELLOW;
                ST_FARM_YELLOW:
                    if (r_phase_time == 8'(YELLOW_T - 1)) w_next = ST_ALL_RED_2;
                ST_ALL_RED_2:
                    if (r_phase_time == 8'(ALL_RED_T - 1))
                        w_next = w_ped_pending ? ST_PED_WALK : ST_HW_GREEN;
                // Only reachable with ped_pending, which is tied low without PED_EN.
                ST_PED_WALK:
                    if (r_phase_time == 8'(WALK_T - 1))
                        w_next = ((r_next_dir == DIR_FARM) && sensor) ? ST_FARM_GREEN : ST_HW_GREEN;
                default:
                    w_next = ST_HW_GREEN;
            endcase
        end
    end

    assign w_enter_walk = (w_next == ST_PED_WALK) && (r_state != ST_PED_WALK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HW_GREEN;
            r_phase_time <= 8'd0;
            r_next_dir   <= DIR_HW;
            r_lamp_hw    <= LAMP_GREEN;
            r_lamp_farm  <= LAMP_RED;
        end else begin
            r_state     <= w_next;
            r_lamp_hw   <= hw_lamp(w_next);
            r_lamp_farm <= farm_lamp(w_next);
            if (w_next != r_state)
                r_phase_time <= 8'd0;
            else if (w_tick && (r_phase_time != 8'hFF))
                r_phase_time <= r_phase_time + 8'd1;
            if (w_enter_walk)
                r_next_dir <= (r_state == ST_ALL_RED_1) ? DIR_FARM : DIR_HW;
        end
    end

`ifdef PED_EN
    logic r_ped_pending;
    logic r_walk;

    // A request arriving in the entry cycle wins, so one more walk is owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped_pending <= 1'b0;
            r_walk        <= 1'b0;
        end else begin
            if (ped_req)
                r_ped_pending <= 1'b1;
            else if (w_enter_walk)
                r_ped_pending <= 1'b0;
            r_walk <= (w_next == ST_PED_WALK);
        end
    end

    assign w_ped_pending = r_ped_pending;
    assign walk          = r_walk;
`else
    assign w_ped_pending = 1'b0;
`endif

    assign light_highway = r_lamp_hw;
    assign light_farm    = r_lamp_farm;
    assign phase         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
// +------------------------------------------------------------------+
// | tb_intersection_scheduler : directed checks of phase sequencing  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_intersection_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor = 1'b1;
    logic       ped_req = 1'b0;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       walk;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .TICK_DIV       (4),
        .HW_MIN_GREEN   (3),
        .FARM_MIN_GREEN (2),
        .FARM_MAX_GREEN (5),
        .YELLOW_T       (2),
        .ALL_RED_T      (1),
        .WALK_T         (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor        (sensor),
`ifdef PED_EN
        .ped_req       (ped_req),
`endif
        .light_highway (light_highway),
        .light_farm    (light_farm),
`ifdef PED_EN
        .walk          (walk),
`endif
        .phase         (phase)
    );

`ifndef PED_EN
    assign walk = 1'b0;
`endif

    task automatic chk(input string tag, input logic [2:0] ehw, input logic [2:0] ef,
                       input logic [2:0] ep, input logic ew);
        n_tests++;
        assert (light_highway === ehw) else begin
            n_fail++;
            $error("FAIL %s light_highway got %b want %b", tag, light_highway, ehw);
        end
        n_tests++;
        assert (light_farm === ef) else begin
            n_fail++;
            $error("FAIL %s light_farm got %b want %b", tag, light_farm, ef);
        end
        n_tests++;
        assert (phase === ep) else begin
            n_fail++;
            $error("FAIL %s phase got %0d want %0d", tag, phase, ep);
        end
`ifdef PED_EN
        n_tests++;
        assert (walk === ew) else begin
            n_fail++;
            $error("FAIL %s walk got %b want %b", tag, walk, ew);
        end
`endif
    endtask

    // Advance n clocks, checking outputs on each falling edge.
    task automatic expect_for(input int n, input string tag, input logic [2:0] ehw,
                              input logic [2:0] ef, input logic [2:0] ep, input logic ew);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), ehw, ef, ep, ew);
        end
    endtask

    initial begin
        // Reset held 10 cycles with sensor and ped_req active.
        rst = 1'b1; sensor = 1'b1; ped_req = 1'b1;
        expect_for(9, "reset", G, R, 3'd0, 1'b0);
        ped_req = 1'b0;
        expect_for(1, "reset_last", G, R, 3'd0, 1'b0);
        rst = 1'b0;

        // Farm service then max green with sensor held high.
        expect_for(11, "fs_hwg",  G, R, 3'd0, 1'b0);
        expect_for(8,  "fs_hwy",  Y, R, 3'd1, 1'b0);
        expect_for(4,  "fs_ar1",  R, R, 3'd2, 1'b0);
        expect_for(20, "mx_fg",   R, G, 3'd3, 1'b0);
        expect_for(8,  "mx_fy",   R, Y, 3'd4, 1'b0);
        expect_for(4,  "mx_ar2",  R, R, 3'd5, 1'b0);

        // Early release: sensor drops one clock into farm green.
        expect_for(12, "er_hwg",  G, R, 3'd0, 1'b0);
        expect_for(8,  "er_hwy",  Y, R, 3'd1, 1'b0);
        expect_for(4,  "er_ar1",  R, R, 3'd2, 1'b0);
        expect_for(1,  "er_fg0",  R, G, 3'd3, 1'b0);
        sensor = 1'b0;
        expect_for(7,  "er_fg",   R, G, 3'd3, 1'b0);
        expect_for(8,  "er_fy",   R, Y, 3'd4, 1'b0);
        expect_for(4,  "er_ar2",  R, R, 3'd5, 1'b0);
        expect_for(30, "er_hold", G, R, 3'd0, 1'b0);

`ifdef PED_EN
        // Pedestrian pulse at cycle 2 after reset, no farm traffic.
        rst = 1'b1;
        expect_for(1, "pd_rst", G, R, 3'd0, 1'b0);
        rst = 1'b0;
        expect_for(2, "pd_hwg_a", G, R, 3'd0, 1'b0);
        ped_req = 1'b1;
        expect_for(1, "pd_hwg_b", G, R, 3'd0, 1'b0);
        ped_req = 1'b0;
        expect_for(8, "pd_hwg_c", G, R, 3'd0, 1'b0);
        expect_for(8, "pd_hwy",   Y, R, 3'd1, 1'b0);
        expect_for(4, "pd_ar1",   R, R, 3'd2, 1'b0);
        expect_for(8, "pd_walk",  R, R, 3'd6, 1'b1);
        expect_for(20, "pd_hwg",  G, R, 3'd0, 1'b0);
`endif

        // Mid-operation reset during farm yellow with a walk pending.
        sensor = 1'b1;
        rst = 1'b1;
        expect_for(1, "mr_rst0", G, R, 3'd0, 1'b0);
        rst = 1'b0;
        expect_for(11, "mr_hwg", G, R, 3'd0, 1'b0);
        expect_for(8,  "mr_hwy", Y, R, 3'd1, 1'b0);
        expect_for(4,  "mr_ar1", R, R, 3'd2, 1'b0);
        expect_for(6,  "mr_fg_a", R, G, 3'd3, 1'b0);
        ped_req = 1'b1;
        expect_for(1,  "mr_fg_b", R, G, 3'd3, 1'b0);
        ped_req = 1'b0;
        expect_for(13, "mr_fg_c", R, G, 3'd3, 1'b0);
        expect_for(2,  "mr_fy",   R, Y, 3'd4, 1'b0);
        rst = 1'b1;
        sensor = 1'b0;
        expect_for(1,  "mr_rst",  G, R, 3'd0, 1'b0);
        rst = 1'b0;
        expect_for(40, "mr_after", G, R, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intersection_scheduler.md
# intersection_scheduler

Phase scheduler that shares the intersection between highway traffic, farm-road traffic and an optional pedestrian crossing. It drives the highway and farm-road lamp outputs directly. It replaces a fixed sensor-driven sequencer with a prescaled, tick-based timer that enforces minimum green, maximum farm green, yellow and all-red clearance intervals. It sits at the top of the traffic controller, clocked from the 1 MHz system clock.

## Interface
- TICK_DIV, 1000: clk cycles per timing tick (1 ms at 1 MHz); range 2..65535
- HW_MIN_GREEN, 25: minimum highway green, ticks
- FARM_MIN_GREEN, 5: minimum farm green, ticks
- FARM_MAX_GREEN, 15: maximum farm green, ticks
- YELLOW_T, 3: yellow duration, ticks
- ALL_RED_T, 1: all-red clearance, ticks
- WALK_T, 10: pedestrian walk duration, ticks
- All durations are in the range 1..255.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- sensor  in  1  farm-road vehicle present, level
- ped_req  in  1  pedestrian button, pulse or level (PED_EN only)
- light_highway  out  3  {red,yellow,green}: 100 red, 010 yellow, 001 green
- light_farm  out  3  same encoding
- walk  out  1  pedestrian walk lamp (PED_EN only)
- phase  out  3  current state code

## Operation
- States and codes:
  - HW_GREEN (0)
  - HW_YELLOW (1)
  - ALL_RED_1 (2)
  - FARM_GREEN (3)
  - FARM_YELLOW (4)
  - ALL_RED_2 (5)
  - PED_WALK (6)
- Lamp outputs and walk are a Moore decode of the state register.
  - HW_GREEN: highway 001, farm 100.
  - HW_YELLOW: highway 010, farm 100.
  - FARM_GREEN: highway 100, farm 001.
  - FARM_YELLOW: highway 100, farm 010.
  - ALL_RED_x and PED_WALK: both 100.
  - walk is 1 only in PED_WALK.
- phase_time is an 8-bit counter. It clears on every state entry, increments on each tick, and saturates at 255.
- "Expires(D)" means tick is high and phase_time == D-1.
- Transitions:
  - HW_GREEN → HW_YELLOW: on a tick with phase_time ≥ HW_MIN_GREEN-1 and (sensor or ped_pending).
  - HW_YELLOW → ALL_RED_1: Expires(YELLOW_T).
  - ALL_RED_1, on Expires(ALL_RED_T):
    - → PED_WALK if ped_pending, with next_dir = FARM.
    - else → FARM_GREEN if sensor.
    - else → HW_GREEN.
  - FARM_GREEN → FARM_YELLOW: on a tick with phase_time ≥ FARM_MIN_GREEN-1 and !sensor, or on Expires(FARM_MAX_GREEN).
  - FARM_YELLOW → ALL_RED_2: Expires(YELLOW_T).
  - ALL_RED_2, on Expires(ALL_RED_T):
    - → PED_WALK if ped_pending, with next_dir = HW.
    - else → HW_GREEN.
  - PED_WALK, on Expires(WALK_T):
    - → FARM_GREEN if next_dir = FARM and sensor.
    - else → HW_GREEN.
- ped_pending is set by ped_req and cleared on entry to PED_WALK. If set and clear occur in the same cycle, set wins and one further walk is scheduled.
- Green is never granted to both roads. Every direction change passes through yellow and then all-red.

## Timing
- Tick prescaler tick_cnt counts 0..TICK_DIV-1. tick is high for one cycle when tick_cnt == TICK_DIV-1.
- A state change takes effect on the clock edge at the end of the tick cycle. Outputs change in the same cycle the state register updates; there is no extra pipeline stage.
- State durations:
  - Timed states last exactly D×TICK_DIV clocks.
  - HW_GREEN lasts at least HW_MIN_GREEN×TICK_DIV clocks.
  - FARM_GREEN lasts at most FARM_MAX_GREEN×TICK_DIV clocks.
- sensor and ped_req are sampled only on tick cycles for transition decisions. ped_req is latched on every cycle.
- Reset (rst high at a rising edge), which may occur in any state:
  - state = HW_GREEN, tick_cnt = 0, phase_time = 0, ped_pending = 0, next_dir = HW.
  - Outputs: light_highway = 001, light_farm = 100, walk = 0, phase = 0.
  - Outputs hold these values while rst is high, regardless of inputs.

## Configuration
- PED_EN:
  - Defined: ped_req and walk ports exist; PED_WALK is reachable; ped_pending logic is built.
  - Undefined: those ports and the PED_WALK state are removed, ped_pending is treated as 0, and the other transitions are unchanged.

## Structure
- Package traffic_pkg holds:
  - state codes
  - lamp encodings LAMP_RED = 3'b100, LAMP_YELLOW = 3'b010, LAMP_GREEN = 3'b001
  - the next_dir encoding
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick) implements the prescaler. The FSM, phase_time, ped_pending and the output decode live in the top module.

## Test plan
All scenarios use TICK_DIV=4, HW_MIN_GREEN=3, FARM_MIN_GREEN=2, FARM_MAX_GREEN=5, YELLOW_T=2, ALL_RED_T=1, WALK_T=2.
- Reset: rst high for 10 cycles with sensor=1 → light_highway=001, light_farm=100, walk=0, phase=0 throughout.
- Farm service: sensor=1 from rst release → highway green for 12 clocks, highway yellow 8, all-red 4, then farm 001.
- Max green: sensor held high → farm green exactly 20 clocks, then farm 010 for 8, all-red 4, highway 001.
- Early release: sensor drops 1 clock into farm green → farm yellow begins after exactly 8 clocks (min green).
- Pedestrian: ped_req 1-cycle pulse at cycle 2 with sensor=0 → HW_GREEN, HW_YELLOW, ALL_RED_1, then PED_WALK (walk=1, both 100) for 8 clocks, then HW_GREEN because sensor=0.
- Mid-operation reset: rst pulsed during FARM_YELLOW with ped_pending=1 → next cycle highway 001, farm 100, no walk served afterward.
